// File: rtl/cm163_count_reg.sv
// Presettable binary counter built from NIBBLES cascaded 4-bit slices. Clear and load each take effect at the next edge.
// Each wrap gives a one-cycle tc_pulse and sets a sticky ovf. Load backpressure is ld_ready, low during reset and clr.
module cm163_count_reg #(
  parameter int                   NIBBLES      = 4,
  parameter bit                   RELOAD_ON_TC = 1'b0,
  parameter logic [4*NIBBLES-1:0] RELOAD_VAL   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4*NIBBLES-1:0]   ld_data,
  input  logic                   en_p,
  input  logic                   en_t,
  output logic [4*NIBBLES-1:0]   cnt,
  output logic                   rco,
  output logic                   tc_pulse,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int W = 4 * NIBBLES;

  logic [W-1:0]     r_cnt;
  logic             r_tc;
  logic             r_ovf;
  logic             r_ready;

  logic [NIBBLES:0] w_carry;
  logic [W-1:0]     w_cnt_inc;
  logic [W-1:0]     w_cnt_nxt;
  logic             w_count;
  logic             w_ld_acc;
  logic             w_wrap;

  assign w_count    = en_p & en_t;
  assign w_carry[0] = w_count;
  assign ld_ready   = r_ready & ~clr;
  assign w_ld_acc   = ld_valid & ld_ready;

  // A slice advances only when every lower slice is all ones.
  for (genvar g = 0; g < NIBBLES; g++) begin : g_slice
    assign w_cnt_inc[4*g +: 4] = r_cnt[4*g +: 4] + {3'b000, w_carry[g]};
    assign w_carry[g+1]        = w_carry[g] & (&r_cnt[4*g +: 4]);
  end

  assign w_wrap = w_carry[NIBBLES] & ~clr & ~w_ld_acc;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (w_ld_acc) begin
      w_cnt_nxt = ld_data;
    end else if (w_carry[NIBBLES]) begin
      w_cnt_nxt = RELOAD_ON_TC ? RELOAD_VAL : '0;
    end else if (w_count) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_tc    <= w_wrap;
      r_ovf   <= w_wrap | (r_ovf & ~ovf_clr);
      r_ready <= 1'b1;
    end
  end

  assign cnt      = r_cnt;
  assign tc_pulse = r_tc;
  assign ovf      = r_ovf;
  assign rco      = en_t & (&r_cnt);

endmodule
